// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared definitions for the RAM arbiter slice: default bus widths, the
// sequencer state encoding and the RAM rw pin encoding.
package ram_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin picker, purely combinational.
// Ports:
//   req[1:0]    request lines, bit N = requester N
//   last_grant  index of the requester granted most recently
//   en          arbitration enable; no grant is issued while low
//   gnt[1:0]    one-hot grant (all zero when disabled or nothing requested)
//   gnt_idx     index of the winning requester (0 when nothing requested)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx = 1'b0;
        // On a tie the requester that did not win last time goes first.
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end

        gnt = 2'b00;
        if (en && (req != 2'b00)) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Round-robin arbiter and sequencer that serialises read/write requests from
// two requesters onto a single-port RAM (write with rw=1 on a rising edge,
// read data on dout one cycle after the address is presented).
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   reqN_valid/rw/addr/wdata  request from requester N (rw: 1=write, 0=read)
//   reqN_ready                request accepted on this cycle's rising edge
//   reqN_done                 one-cycle completion pulse
//   reqN_rdata                read data, valid while reqN_done=1
//   ram_addr/ram_din/ram_rw   RAM drive
//   ram_dout                  RAM read data
module ram_arbiter #(
    parameter int ADDR_W = ram_ctrl_pkg::ADDR_W,
    parameter int DATA_W = ram_ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,

    input  logic              req1_valid,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_dout
);

    import ram_ctrl_pkg::*;

    state_t            state, state_nxt;
    logic              last_grant;
    logic              cur;        // requester owning the transaction in flight
    logic              lat_rw;
    logic              arb_en;
    logic [1:0]        gnt;
    logic              gnt_idx;
    logic              accept;
    logic              sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rdata0, rdata1;

    // Arbitration only in IDLE; held off during reset so ready reads 0 there.
    assign arb_en = (state == IDLE) && !rst;

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .en         (arb_en),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign accept     = |gnt;
    assign req0_rdata = rdata0;
    assign req1_rdata = rdata1;

    always_comb begin
        sel_rw    = req0_rw;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        if (gnt_idx) begin
            sel_rw    = req1_rw;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req0_done = 1'b0;
        req1_done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = (lat_rw == RW_WRITE) ? DONE : CAPTURE;
            end
            CAPTURE: begin
                state_nxt = DONE;
            end
            DONE: begin
                req0_done = !cur;
                req1_done = cur;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accept: latch the request straight into the RAM address/data registers
    // so it is on the RAM pins during ACCESS. ram_rw is high only for the
    // single ACCESS cycle of a write; every other edge clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            cur        <= 1'b0;
            lat_rw     <= RW_READ;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_rw     <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            ram_rw <= 1'b0;
            if (accept) begin
                last_grant <= gnt_idx;
                cur        <= gnt_idx;
                lat_rw     <= sel_rw;
                ram_addr   <= sel_addr;
                ram_din    <= sel_wdata;
                ram_rw     <= (sel_rw == RW_WRITE);
            end
            // Capture: RAM output is valid during CAPTURE; only the owner's
            // rdata changes, so the other requester's last read is kept.
            if (state == CAPTURE) begin
                if (cur) begin
                    rdata1 <= ram_dout;
                end else begin
                    rdata0 <= ram_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed testbench for ram_arbiter with a behavioural single-port RAM.
module tb_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req0_rw = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req0_ready, req0_done;
    logic [DW-1:0] req0_rdata;
    logic          req1_valid = 1'b0, req1_rw = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req1_ready, req1_done;
    logic [DW-1:0] req1_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_rw;
    logic [DW-1:0] ram_dout;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [DW-1:0] mem [0:65535];

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_rw    (req0_rw),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req0_rdata (req0_rdata),
        .req1_valid (req1_valid),
        .req1_rw    (req1_rw),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .req1_rdata (req1_rdata),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_rw     (ram_rw),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM: write on rising edge with rw=1, registered read.
    always @(posedge clk) begin
        if (ram_rw) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called just after a negedge with valid driven. Returns the number of
    // cycles waited until ready is seen (still in that cycle), -1 on timeout.
    task automatic wait_ready(input int n, output int waited);
        waited = 0;
        forever begin
            #1;
            if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) return;
            @(negedge clk);
            waited++;
            if (waited > 20) begin
                waited = -1;
                return;
            end
        end
    endtask

    // Steps negedges until done of requester n is seen; returns cycles stepped
    // or -1 on timeout.
    task automatic wait_done(input int n, output int waited);
        waited = 0;
        forever begin
            @(negedge clk);
            waited++;
            if ((n == 0 && req0_done) || (n == 1 && req1_done)) return;
            if (waited > 20) begin
                waited = -1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int w;
        int dones;
        repeat (2) @(negedge clk);
        vectors++; if (ram_rw !== 1'b0) begin errors++; $display("FAIL rst_ram_rw: got %0b want 0", ram_rw); end
        vectors++; if (ram_addr !== 16'h0) begin errors++; $display("FAIL rst_ram_addr: got %h want 0000", ram_addr); end
        vectors++; if (ram_din !== 32'h0) begin errors++; $display("FAIL rst_ram_din: got %h want 0", ram_din); end
        vectors++; if ({req0_done, req1_done} !== 2'b00) begin errors++; $display("FAIL rst_done: got %b want 00", {req0_done, req1_done}); end
        vectors++; if ({req0_rdata, req1_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {req0_rdata, req1_rdata}); end
        rst = 1'b0;
        // Start a write, then hit reset asynchronously in the middle of ACCESS.
        @(negedge clk);
        req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 16'h5A5A; req0_wdata = 32'hA5A5A5A5;
        wait_ready(0, w);
        vectors++; if (w !== 0) begin errors++; $display("FAIL rst_pre_ready_wait: got %0d want 0", w); end
        @(posedge clk);
        #2;
        vectors++; if (ram_rw !== 1'b1 || ram_addr !== 16'h5A5A) begin errors++; $display("FAIL rst_pre_access: rw %0b addr %h want 1 5a5a", ram_rw, ram_addr); end
        rst = 1'b1;
        #1;
        vectors++; if (ram_rw !== 1'b0) begin errors++; $display("FAIL rst_async_rw: got %0b want 0", ram_rw); end
        vectors++; if (ram_addr !== 16'h0 || ram_din !== 32'h0) begin errors++; $display("FAIL rst_async_bus: addr %h din %h want 0 0", ram_addr, ram_din); end
        vectors++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_async_ready: got %0b want 0 (valid held)", req0_ready); end
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (req0_done || req1_done) dones++;
        end
        vectors++; if (dones !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", dones); end
        vectors++; if (ram_rw !== 1'b0 || req0_ready !== 1'b0) begin errors++; $display("FAIL rst_idle: rw %0b ready %0b want 0 0", ram_rw, req0_ready); end
    endtask

    task automatic test_write_read();
        int w;
        req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 16'hABCD; req0_wdata = 32'h11001100;
        wait_ready(0, w);
        vectors++; if (w !== 0) begin errors++; $display("FAIL wr_ready_wait: got %0d want 0", w); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        vectors++; if (ram_rw !== 1'b1 || ram_addr !== 16'hABCD || ram_din !== 32'h11001100) begin errors++; $display("FAIL wr_access: rw %0b addr %h din %h want 1 abcd 11001100", ram_rw, ram_addr, ram_din); end
        vectors++; if (req0_done !== 1'b0) begin errors++; $display("FAIL wr_early_done: got %0b want 0", req0_done); end
        @(negedge clk);
        vectors++; if (ram_rw !== 1'b0 || req0_done !== 1'b1) begin errors++; $display("FAIL wr_done: rw %0b done %0b want 0 1", ram_rw, req0_done); end
        @(negedge clk);
        vectors++; if (req0_done !== 1'b0 || ram_addr !== 16'hABCD) begin errors++; $display("FAIL wr_after: done %0b addr %h want 0 abcd", req0_done, ram_addr); end
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 16'hABCD; req0_wdata = 32'h0;
        wait_ready(0, w);
        vectors++; if (w !== 0) begin errors++; $display("FAIL rd_ready_wait: got %0d want 0", w); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        vectors++; if (ram_rw !== 1'b0 || ram_addr !== 16'hABCD) begin errors++; $display("FAIL rd_access: rw %0b addr %h want 0 abcd", ram_rw, ram_addr); end
        wait_done(0, w);
        vectors++; if (w !== 2) begin errors++; $display("FAIL rd_latency: done after %0d want 2", w); end
        vectors++; if (req0_rdata !== 32'h11001100) begin errors++; $display("FAIL rd_data: got %h want 11001100", req0_rdata); end
        @(negedge clk);
        vectors++; if (req0_done !== 1'b0 || req0_rdata !== 32'h11001100) begin errors++; $display("FAIL rd_hold: done %0b rdata %h want 0 11001100", req0_done, req0_rdata); end
    endtask

    task automatic test_tie();
        int w;
        rst = 1'b1;
        req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 16'h0011; req0_wdata = 32'h01011010;
        req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 16'h0011; req1_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL tie_first: ready1,0 %b want 01", {req1_ready, req0_ready}); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        vectors++; if (ram_rw !== 1'b1 || ram_din !== 32'h01011010 || req1_ready !== 1'b0) begin errors++; $display("FAIL tie_wr: rw %0b din %h rdy1 %0b want 1 01011010 0", ram_rw, ram_din, req1_ready); end
        wait_ready(1, w);
        vectors++; if (w !== 2) begin errors++; $display("FAIL tie_second: req1 waited %0d want 2", w); end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_done(1, w);
        vectors++; if (w !== 2) begin errors++; $display("FAIL tie_rd_latency: got %0d want 2", w); end
        vectors++; if (req1_rdata !== 32'h01011010) begin errors++; $display("FAIL tie_rdata: got %h want 01011010", req1_rdata); end
        vectors++; if (req0_rdata !== 32'h0 || req0_done !== 1'b0) begin errors++; $display("FAIL tie_req0_side: rdata %h done %0b want 0 0", req0_rdata, req0_done); end
    endtask

    task automatic test_fairness();
        int cnt;
        int prev;
        int g;
        @(negedge clk);
        req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 16'h0100; req0_wdata = 32'hAAAA0000;
        req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 16'h0101; req1_wdata = 32'hBBBB1111;
        cnt  = 0;
        prev = 0;
        for (int c = 0; c < 100 && cnt < 8; c++) begin
            #1;
            if (req0_ready && req1_ready) begin
                vectors++; errors++; $display("FAIL fair_both_ready: got 11 want one-hot");
            end
            if (req0_ready || req1_ready) begin
                g = req1_ready ? 1 : 0;
                vectors++; if (g !== cnt % 2) begin errors++; $display("FAIL fair_order: grant %0d got %0d want %0d", cnt, g, cnt % 2); end
                if (cnt > 0) begin
                    vectors++; if (cyc - prev !== 3) begin errors++; $display("FAIL fair_gap: grant %0d gap %0d want 3", cnt, cyc - prev); end
                end
                prev = cyc;
                cnt++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        vectors++; if (cnt !== 8) begin errors++; $display("FAIL fair_count: got %0d grants want 8", cnt); end
        repeat (3) @(negedge clk);
        vectors++; if (mem[16'h0100] !== 32'hAAAA0000 || mem[16'h0101] !== 32'hBBBB1111) begin errors++; $display("FAIL fair_mem: %h %h want aaaa0000 bbbb1111", mem[16'h0100], mem[16'h0101]); end
    endtask

    task automatic test_reset_access();
        int w;
        int dones;
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 16'hABCD;
        wait_ready(0, w);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        vectors++; if (ram_addr !== 16'hABCD || ram_rw !== 1'b0) begin errors++; $display("FAIL rsta_access: addr %h rw %0b want abcd 0", ram_addr, ram_rw); end
        rst = 1'b1;
        #1;
        vectors++; if (ram_addr !== 16'h0 || req0_rdata !== 32'h0) begin errors++; $display("FAIL rsta_values: addr %h rdata %h want 0 0", ram_addr, req0_rdata); end
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (req0_done || req1_done) dones++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (req0_done || req1_done) dones++;
        end
        vectors++; if (dones !== 0) begin errors++; $display("FAIL rsta_no_done: got %0d pulses want 0", dones); end
        req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 16'h0022; req1_wdata = 32'hDEADBEEF;
        wait_ready(1, w);
        vectors++; if (w !== 0) begin errors++; $display("FAIL rsta_grant: waited %0d want 0", w); end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        vectors++; if (ram_rw !== 1'b1 || ram_addr !== 16'h0022 || ram_din !== 32'hDEADBEEF) begin errors++; $display("FAIL rsta_wr: rw %0b addr %h din %h want 1 0022 deadbeef", ram_rw, ram_addr, ram_din); end
        wait_done(1, w);
        vectors++; if (w !== 1) begin errors++; $display("FAIL rsta_latency: got %0d want 1", w); end
    endtask

    task automatic test_back_to_back();
        int w;
        int t_prev;
        // Now in req1's DONE cycle: reassert for a read.
        t_prev = cyc;
        req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 16'h0022;
        #1;
        vectors++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %0b want 0", req1_ready); end
        @(negedge clk);
        #1;
        vectors++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle: got %0b want 1", req1_ready); end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_done(1, w);
        vectors++; if (w < 0 || cyc - t_prev !== 4) begin errors++; $display("FAIL b2b_read_gap: got %0d want 4", cyc - t_prev); end
        vectors++; if (req1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata: got %h want deadbeef", req1_rdata); end
        t_prev = cyc;
        req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 16'h0033; req1_wdata = 32'h12345678;
        #1;
        vectors++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done2: got %0b want 0", req1_ready); end
        @(negedge clk);
        #1;
        vectors++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle2: got %0b want 1", req1_ready); end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_done(1, w);
        vectors++; if (w < 0 || cyc - t_prev !== 3) begin errors++; $display("FAIL b2b_write_gap: got %0d want 3", cyc - t_prev); end
        vectors++; if (req1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata_hold: got %h want deadbeef", req1_rdata); end
        vectors++; if (mem[16'h0033] !== 32'h12345678) begin errors++; $display("FAIL b2b_mem: got %h want 12345678", mem[16'h0033]); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_fairness();
        test_reset_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port 32x16 RAM (ram: addr, din, rw, clk, dout).
- Accepts read/write requests from two requesters, for example instruction fetch (req0) and data load/store (req1).
- Serialises the requests onto the RAM's rw/addr/din pins and returns read data with a completion pulse.
- RAM timing is fixed: write on a rising clk with rw=1; read data appears on dout one cycle after addr is presented with rw=0.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 32, RAM data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req0_valid  in  1  requester 0 has a request pending.
- req0_rw  in  1  1=write, 0=read.
- req0_addr  in  ADDR_W  request address.
- req0_wdata  in  DATA_W  write data.
- req0_ready  out  1  request accepted this cycle.
- req0_done  out  1  one-cycle completion pulse.
- req0_rdata  out  DATA_W  read data, valid while req0_done=1.
- req1_valid, req1_rw, req1_addr, req1_wdata, req1_ready, req1_done, req1_rdata: same as requester 0, for requester 1.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_din  out  DATA_W  to RAM din.
- ram_rw  out  1  to RAM rw.
- ram_dout  in  DATA_W  from RAM dout.

Behaviour:
- Clocking: one clock, clk. rst is asynchronous, active-high.
- Reset values:
  - state=IDLE, last_grant=1, so req0 wins the first tie.
  - ram_rw=0, ram_addr=0, ram_din=0.
  - reqN_done=0, reqN_rdata=0.
  - reqN_ready=0, since it is derived from state.
- States: IDLE, ACCESS, CAPTURE, DONE.
- IDLE:
  - If neither valid, stay in IDLE.
  - If one valid, grant it.
  - If both valid, grant the requester that is not last_grant.
  - reqN_ready is combinational: (state==IDLE) & grant==N & reqN_valid.
  - On accept, latch rw, addr and wdata, update last_grant, and go to ACCESS.
- Requester handshake: hold valid and all fields stable until ready=1. A request is accepted only when valid & ready are both 1 on a rising edge.
- ACCESS (exactly 1 cycle):
  - ram_addr and ram_din are registered from the latch.
  - ram_rw=1 only in this cycle, and only for writes.
  - Write: go to DONE. Read: go to CAPTURE.
- CAPTURE (reads only): sample ram_dout into rdata_reg at the end of the cycle, then go to DONE.
- DONE:
  - The granted reqN_done=1 for exactly one cycle.
  - reqN_rdata = rdata_reg for reads; it holds its last value for writes.
  - Then go to IDLE.
- Latency, with accept at edge T:
  - Write: ram_rw=1 in cycle T+1; done in T+2.
  - Read: addr on the RAM in T+1; captured in T+2; done in T+3.
  - The next accept can happen no earlier than the IDLE cycle after DONE.
- ram_rw is 0 in every state except ACCESS-write, so the RAM sees no spurious writes.
- ram_addr and ram_din hold their last values between accesses.
- Fairness: a continuously-valid requester is granted within one transaction of the other requester. There is no starvation.
- Simultaneous events:
  - A new valid from the non-granted requester during ACCESS/CAPTURE/DONE waits; it is not dropped.
  - A requester may reassert valid in the cycle its done is pulsed; it is arbitrated in the following IDLE.
- Reset mid-operation:
  - Return immediately to reset values.
  - No done pulse for the aborted request.
  - ram_rw drops asynchronously. Whether the RAM contents at that address are updated is unspecified.
- Widths: addresses and data pass through unchanged. There is no arithmetic.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - ADDR_W and DATA_W constants.
  - The state encoding (IDLE=2'd0, ACCESS=2'd1, CAPTURE=2'd2, DONE=2'd3).
  - RW_READ=0 and RW_WRITE=1.
- One sub-module, rr_arb2: a 2-way round-robin picker.
  - Inputs: req[1:0], last_grant, en.
  - Outputs: gnt[1:0], gnt_idx.
  - Purely combinational.
- The top level contains the FSM, the latches and the RAM drive.

Test Plan:
1. Reset: assert rst mid-cycle -> all outputs 0 immediately; after release, IDLE and ram_rw=0.
2. Single write then read: req0 writes addr 16'hABCD, wdata 32'h11001100 -> ram_rw=1 for exactly one cycle with those values; req0_done at T+2. Then req0 reads 16'hABCD -> req0_done at T+3 with req0_rdata=32'h11001100.
3. Tie arbitration: both valid from reset, req0 writes 16'h0011←32'h01011010 and req1 reads 16'h0011 -> req0 is granted first, then req1, and req1_rdata=32'h01011010.
4. Fairness: req0 and req1 continuously valid for 8 transactions -> grants strictly alternate 0,1,0,1…; no requester waits more than one transaction.
5. Reset during ACCESS of a read -> no req0_done pulse; after reset release, a new req1 request is granted first-come with normal latency.
6. Back-to-back: req1 reasserts valid in its own DONE cycle -> ready in the next IDLE cycle; the gap between consecutive done pulses is 4 cycles for reads and 3 for writes.
